// File: rtl/axi4_lite_reg_file.sv
// AXI4-Lite slave register file: DEPTH word registers with byte-strobed writes,
// optional read-only registers sourced from fabric, OKAY/SLVERR/DECERR responses.
module axi4_lite_reg_file #(
  parameter int unsigned                      ADDR_W     = 16,
  parameter int unsigned                      DATA_BYTES = 4,
  parameter int unsigned                      DEPTH      = 8,
  parameter logic [DEPTH-1:0]                 RO_MASK    = '0,
  parameter logic [DEPTH*DATA_BYTES*8-1:0]    RESET_VAL  = '0
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  // AW channel
  input  logic [ADDR_W-1:0]               s_awaddr_i,
  input  logic [2:0]                      s_awprot_i,
  input  logic                            s_awvalid_i,
  output logic                            s_awready_o,
  // W channel
  input  logic [DATA_BYTES*8-1:0]         s_wdata_i,
  input  logic [DATA_BYTES-1:0]           s_wstrb_i,
  input  logic                            s_wvalid_i,
  output logic                            s_wready_o,
  // B channel
  output logic [1:0]                      s_bresp_o,
  output logic                            s_bvalid_o,
  input  logic                            s_bready_i,
  // AR channel
  input  logic [ADDR_W-1:0]               s_araddr_i,
  input  logic [2:0]                      s_arprot_i,
  input  logic                            s_arvalid_i,
  output logic                            s_arready_o,
  // R channel
  output logic [DATA_BYTES*8-1:0]         s_rdata_o,
  output logic [1:0]                      s_rresp_o,
  output logic                            s_rvalid_o,
  input  logic                            s_rready_i,
  // Fabric side
  output logic [DEPTH*DATA_BYTES*8-1:0]   reg_q,
  input  logic [DEPTH*DATA_BYTES*8-1:0]   reg_in,
  output logic [DEPTH-1:0]                wr_pulse,
  // FSM observation
  output logic [2:0]                      wr_state_o,
  output logic [1:0]                      rd_state_o
);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid and ready are both 1; a source holds valid and payload stable until then.

  localparam int unsigned DW    = DATA_BYTES * 8;
  localparam int unsigned OFF_W = $clog2(DATA_BYTES);
  localparam int unsigned IDX_W = ADDR_W - OFF_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    W_INIT    = 3'd0,
    W_IDLE    = 3'd1,
    W_WAIT_W  = 3'd2,
    W_WAIT_AW = 3'd3,
    W_RESP    = 3'd4
  } wr_state_e;

  typedef enum logic [1:0] {
    R_INIT = 2'd0,
    R_IDLE = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [DEPTH-1:0][DW-1:0] regs_q;
  logic [ADDR_W-1:0]        awaddr_q;
  logic [DW-1:0]            wdata_q;
  logic [DATA_BYTES-1:0]    wstrb_q;
  logic [1:0]               bresp_q;
  logic [DEPTH-1:0]         wr_pulse_q;
  logic [DW-1:0]            rdata_q;
  logic [1:0]               rresp_q;

  logic aw_hs, w_hs, ar_hs, commit;

  // Commit-time view: whichever of AW/W arrives on this edge is used directly.
  logic [ADDR_W-1:0]     c_addr;
  logic [DW-1:0]         c_data;
  logic [DATA_BYTES-1:0] c_strb;
  logic [IDX_W-1:0]      c_idx;
  logic                  c_in_range;
  logic                  c_is_ro;
  logic [DEPTH-1:0]      wsel;

  logic [IDX_W-1:0] r_idx;
  logic             r_in_range;
  logic [DW-1:0]    r_data;

  // ---------------- write FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_INIT;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    commit     = 1'b0;
    case (wr_state_q)
      W_INIT: wr_state_d = W_IDLE;
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_d = W_RESP;
          commit     = 1'b1;
        end else if (aw_hs) begin
          wr_state_d = W_WAIT_W;
        end else if (w_hs) begin
          wr_state_d = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        if (w_hs) begin
          wr_state_d = W_RESP;
          commit     = 1'b1;
        end
      end
      W_WAIT_AW: begin
        if (aw_hs) begin
          wr_state_d = W_RESP;
          commit     = 1'b1;
        end
      end
      W_RESP: begin
        if (s_bready_i) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_INIT;
    endcase
  end

  always_comb begin
    s_awready_o = (wr_state_q == W_IDLE) || (wr_state_q == W_WAIT_AW);
    s_wready_o  = (wr_state_q == W_IDLE) || (wr_state_q == W_WAIT_W);
    s_bvalid_o  = (wr_state_q == W_RESP);
  end

  assign aw_hs = s_awvalid_i && s_awready_o;
  assign w_hs  = s_wvalid_i && s_wready_o;

  always_comb begin
    c_addr     = aw_hs ? s_awaddr_i : awaddr_q;
    c_data     = w_hs ? s_wdata_i : wdata_q;
    c_strb     = w_hs ? s_wstrb_i : wstrb_q;
    c_idx      = c_addr[ADDR_W-1:OFF_W];
    c_in_range = (32'(c_idx) < DEPTH);
    c_is_ro    = 1'b0;
    wsel       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (c_idx == IDX_W'(i)) begin
        c_is_ro = RO_MASK[i];
        wsel[i] = ~RO_MASK[i];
      end
    end
  end

  // RO slices stay at zero; their visible value comes from reg_in on reads.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RO_MASK[i] ? {DW{1'b0}} : RESET_VAL[i*DW +: DW];
      end
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      if (aw_hs) begin
        awaddr_q <= s_awaddr_i;
      end
      if (w_hs) begin
        wdata_q <= s_wdata_i;
        wstrb_q <= s_wstrb_i;
      end
      wr_pulse_q <= commit ? wsel : '0;
      if (commit) begin
        if (!c_in_range) begin
          bresp_q <= RESP_DECERR;
        end else if (c_is_ro) begin
          bresp_q <= RESP_SLVERR;
        end else begin
          bresp_q <= RESP_OKAY;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (wsel[i]) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
              if (c_strb[b]) begin
                regs_q[i][b*8 +: 8] <= c_data[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_INIT;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_INIT: rd_state_d = R_IDLE;
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_rready_i) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_INIT;
    endcase
  end

  always_comb begin
    s_arready_o = (rd_state_q == R_IDLE);
    s_rvalid_o  = (rd_state_q == R_RESP);
  end

  assign ar_hs = s_arvalid_i && s_arready_o;

  always_comb begin
    r_idx      = s_araddr_i[ADDR_W-1:OFF_W];
    r_in_range = (32'(r_idx) < DEPTH);
    r_data     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_idx == IDX_W'(i)) begin
        r_data = RO_MASK[i] ? reg_in[i*DW +: DW] : regs_q[i];
      end
    end
  end

  // regs_q is sampled before any same-edge commit lands, so a colliding read
  // returns the pre-write value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= r_data;
      rresp_q <= r_in_range ? RESP_OKAY : RESP_DECERR;
    end
  end

  // ---------------- outputs ----------------
  assign s_bresp_o  = bresp_q;
  assign s_rdata_o  = rdata_q;
  assign s_rresp_o  = rresp_q;
  assign reg_q      = regs_q;
  assign wr_pulse   = wr_pulse_q;
  assign wr_state_o = wr_state_q;
  assign rd_state_o = rd_state_q;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_awprot_i, s_arprot_i, s_awaddr_i, s_araddr_i};

endmodule

// File: doc/axi4_lite_reg_file.md
# axi4_lite_reg_file

Parametrised AXI4-Lite slave register file, the successor to the fixed-response terminus slave. It decodes `DEPTH` word-addressed registers behind one `axi4_lite_if` slave port, applies per-byte `WSTRB` writes, and supports per-register read-only mapping to fabric inputs. It returns OKAY, SLVERR or DECERR per access. It sits at the leaf of the AXI4-Lite interconnect as the control/status block for a peripheral.

## Interface
- `C`, `'{default:0, A:16, N:4}`: `axi4_lite_cfg_t`; `C.A` address bits, `C.N` data bytes (power of 2).
- `DEPTH`, 8: number of registers (1..2^(C.A-log2(C.N))).
- `RO_MASK`, 0: `DEPTH` bits; bit i=1 makes register i read-only, sourced from `reg_in`.
- `RESET_VAL`, 0: `DEPTH*C.N*8` bits; reset value of register i at slice i.
- `aclk  in  1`: clock; all logic on its rising edge.
- `aresetn  in  1`: reset; asynchronous, active-low.
- `axi4_s  slave  axi4_lite_if #(C)`: AXI4-Lite AW/W/B/AR/R channels.
- `reg_q  out  DEPTH*C.N*8`: current register contents; slice i is register i (RW registers only; RO slices read 0).
- `reg_in  in  DEPTH*C.N*8`: read data for RO registers, sampled at AR handshake.
- `wr_pulse  out  DEPTH`: bit i high one cycle after a committed write to RW register i.

## Operation
- Decode: `idx = addr[C.A-1:log2(C.N)]`; low `log2(C.N)` address bits ignored. `idx >= DEPTH` is out of range. AWPROT/ARPROT ignored.
- Write path states:
  - IDLE: AW and W accepted independently; each is captured and its ready drops.
  - COMMIT: taken on the edge where the second of AW/W is captured, or both on the same edge. That edge:
    - in-range RW: bytes with `wstrb[b]=1` updated, other bytes kept; `bresp=OKAY`; `wr_pulse[idx]=1` for one cycle.
    - in-range RO: no update, no pulse; `bresp=SLVERR` (2'b10).
    - out of range: no update, no pulse; `bresp=DECERR` (2'b11).
  - `bvalid=1`, held with `bresp` stable until `bready`.
  - RESP: on the B handshake edge, `bvalid` goes 0 and `awready`/`wready` return to 1.
  - At most one write outstanding.
  - `wstrb=0` to an in-range RW register gives OKAY with no data change and `wr_pulse` still asserted.
- Read path:
  - On the AR handshake edge, `rdata` is captured: the RW register, `reg_in` slice for RO, or 0 out of range.
  - `rresp` is OKAY, or DECERR when out of range. Reads of RO registers are OKAY.
  - `rvalid=1`, held with `rdata`/`rresp` stable until `rready`. At most one read outstanding.
- Read/write channels are independent. AR and a write COMMIT to the same register on the same edge: `rdata` returns the pre-write value.

## Timing
- While `aresetn`=0 (asynchronous):
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid`, `wr_pulse` = 0.
  - `bresp`, `rresp`, `rdata` = 0.
  - `reg_q` = `RESET_VAL` (RO slices 0).
- First rising edge with `aresetn`=1: `awready`, `wready`, `arready` go 1.
- AW+W both valid at edge E: captured at E. In cycle E+1: `bvalid`=1, `reg_q` updated, `wr_pulse`=1.
- AW at E, W at E+k: `wready` stays 1 until E+k; COMMIT at E+k.
- With `bready` held 1, the B handshake occurs at E+1 and the next AW/W can be accepted at E+2. Sustained throughput is one write per 2 cycles.
- AR at E: `rvalid`=1 in E+1. With `rready`=1, `arready` returns at E+2. Sustained throughput is one read per 2 cycles.
- `bvalid`/`rvalid` never drop without a handshake. Ready outputs do not depend combinationally on any valid.
- Reset asserted mid-transaction: the transaction is aborted with no response issued. A partial write (AW captured, W not) is discarded.

## Test plan
- Reset values, with `RESET_VAL` slice 2 = 32'h0000_00A5:
  - read 'h08 -> `rdata`=32'h0000_00A5, OKAY.
  - read 'h04 -> 32'h0, OKAY.
  - all readies 0 during reset, 1 one edge after release.
- Full and strobed write (C.A=16, C.N=4, DEPTH=8):
  - write 'h04 = 32'hABBA_BEEF, `wstrb`=4'hF -> OKAY; `wr_pulse`=8'h02 for one cycle; read 'h04 = 32'hABBA_BEEF.
  - then write 32'h1122_3344, `wstrb`=4'b0101 -> read 32'hAB22_BE44.
- RO register, `RO_MASK`=8'h80, `reg_in` slice 7 = 32'hDEAD_0007:
  - write 'h1C -> SLVERR, no `wr_pulse`.
  - read 'h1C -> 32'hDEAD_0007, OKAY.
- Out of range: write 'h20 = 32'h5555_5555 -> DECERR, no register changes; read 'h20 -> `rdata`=0, DECERR.
- Channel skew and backpressure:
  - AW 'h0C at cycle 0, W 32'h0000_CAFE at cycle 3 -> COMMIT at 3.
  - `bready` low 5 cycles -> `bvalid`/`bresp` held stable, no new AW/W accepted.
  - read 'h0C -> 32'h0000_CAFE.
- Collision and reset abort:
  - AR 'h04 on the same edge as COMMIT 'h04 = 32'h0000_0001 -> `rdata` = old value 32'hAB22_BE44.
  - `aresetn` pulsed low with AW captured and W pending -> no B, `reg_q` = `RESET_VAL`.
